// File: rtl/multiplicador_serial_if.sv
// multiplicador_serial_if: start/operand/result bundle between a requester and the serial multiplier
interface multiplicador_serial_if #(parameter int LARGURA = 4) ();
  logic                 Iniciar;
  logic                 ComSinal;
  logic [LARGURA-1:0]   OperandoA;
  logic [LARGURA-1:0]   OperandoB;
  logic [2*LARGURA-1:0] Produto;
  logic                 Pronto;
  logic                 Ocupado;
  modport master (output Iniciar, ComSinal, OperandoA, OperandoB, input Produto, Pronto, Ocupado);
  modport slave (input Iniciar, ComSinal, OperandoA, OperandoB, output Produto, Pronto, Ocupado);
endinterface

// File: rtl/multiplicador_serial.sv
// multiplicador_serial: shift-add multiplier, one step per clock, signed via magnitude and final negation
module multiplicador_serial #(parameter int LARGURA = 4) (
  input logic Clock,
  input logic Reset,
  multiplicador_serial_if.slave bus
);
  localparam int CW = (LARGURA > 2) ? $clog2(LARGURA) : 1;
  typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTE, FIM} estado_t;
  estado_t r_estado, w_prox;
  logic                 r_sinal, r_pronto, r_ocupado;
  logic [LARGURA-1:0]   r_mcand, r_acc, r_mult;
  logic [CW-1:0]        r_cnt;
  logic [2*LARGURA-1:0] r_produto;
  logic [LARGURA:0]     w_soma;
  logic [LARGURA-1:0]   w_abs_a, w_abs_b;
  logic [2*LARGURA-1:0] w_mag;
  logic                 w_ultimo;
  // -2^(LARGURA-1) negates to itself, which read unsigned is the correct magnitude
  assign w_abs_a  = (bus.ComSinal && bus.OperandoA[LARGURA-1]) ? -bus.OperandoA : bus.OperandoA;
  assign w_abs_b  = (bus.ComSinal && bus.OperandoB[LARGURA-1]) ? -bus.OperandoB : bus.OperandoB;
  assign w_soma   = {1'b0, r_acc} + (r_mult[0] ? {1'b0, r_mcand} : '0);
  assign w_mag    = {r_acc, r_mult};
  assign w_ultimo = r_cnt == CW'(LARGURA - 1);
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  w_prox = bus.Iniciar ? CALCULA : OCIOSO;
      CALCULA: w_prox = w_ultimo ? AJUSTE : CALCULA;
      AJUSTE:  w_prox = FIM;
      default: w_prox = OCIOSO;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) r_estado <= OCIOSO;
    else r_estado <= w_prox;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sinal   <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mult    <= '0;
      r_cnt     <= '0;
      r_produto <= '0;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_ocupado <= w_prox != OCIOSO;
      r_pronto  <= r_estado == AJUSTE;
      case (r_estado)
        OCIOSO: if (bus.Iniciar) begin
          r_sinal <= bus.ComSinal & (bus.OperandoA[LARGURA-1] ^ bus.OperandoB[LARGURA-1]);
          r_mcand <= w_abs_a;
          r_mult  <= w_abs_b;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        CALCULA: begin
          {r_acc, r_mult} <= {w_soma, r_mult[LARGURA-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        AJUSTE: r_produto <= r_sinal ? -w_mag : w_mag;
        default: ;
      endcase
    end
  end
  assign bus.Produto = r_produto;
  assign bus.Pronto  = r_pronto;
  assign bus.Ocupado = r_ocupado;
endmodule
